multicycle_control: RTL and testbench

- Multicycle successor to the single-cycle main decoder.
- Sequences each MIPS instruction (R-type, addi, lw, sw, beq, optional bne, j) through a registered FSM over 3-5 states.
- Supports optional memory wait-states via an ack handshake and traps illegal opcodes.
- Drives the shared-memory multicycle datapath: PC, IR, register file, ALU muxes and memory.

---
 rtl/multicycle_control_pkg.sv | 60 ++++++
 rtl/multicycle_control_dec.sv | 70 +++++++
 rtl/multicycle_control.sv | 118 +++++++++++
 tb/tb_multicycle_control.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// ALU and datapath mux select codes, and the bundled control word.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALU_FUNCT = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_SUB   = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       br_ne;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_dec.sv
// Moore control decode from the current state; only the FETCH IR/PC write
// strobes depend on the (already USE_ACK-qualified) memory acknowledge.
module multicycle_control_dec
  import multicycle_control_pkg::*;
(
  input  state_t     state,
  input  logic       ack,
  input  logic [5:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_rd    = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_wr     = ack;
        ctrl.pc_wr     = ack;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_rd = 1'b1;
        ctrl.iord   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_wr = 1'b1;
        ctrl.iord   = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.reg_dst = 1'b1;
      end
      S_IWB: ctrl.reg_wr = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_RT;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_wr_cond = 1'b1;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.br_ne      = (op == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_wr  = 1'b1;
        ctrl.pc_src = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: state register, next-state sequencing and the
// sticky illegal-opcode flag; datapath controls come from the decode block.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | read instruction, PC += 4 on ack
// DECODE | register read, branch target into ALUOut
// MEMADR | lw/sw effective address
// MEMRD  | data read, hold until ack
// MEMWB  | MDR -> rt
// MEMWR  | data write, hold until ack
// EXEC   | R-type ALU operation
// RWB    | ALUOut -> rd
// BRANCH | compare, conditional PC write
// JUMP   | PC <- jump target
// IEXEC  | addi ALU operation
// IWB    | ALUOut -> rt
// TRAP   | illegal opcode, left only by reset
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit USE_ACK = 1'b1,
  parameter bit BNE_EN  = 1'b1,
  parameter bit TRAP_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [5:0] Op_i,
  input  logic       mem_ack_i,
  output logic       pc_wr_o,
  output logic       pc_wr_cond_o,
  output logic       br_ne_o,
  output logic [1:0] pc_src_o,
  output logic       iord_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       ir_wr_o,
  output logic       reg_wr_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_t state, state_nxt, bad_nxt;
  logic   ack, illegal;
  ctrl_t  ctrl;

  assign ack     = USE_ACK ? mem_ack_i : 1'b1;
  assign bad_nxt = TRAP_EN ? S_TRAP : S_FETCH;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_i) state_nxt = S_FETCH;
      S_FETCH:  if (ack) state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op_i)
          OP_R:         state_nxt = S_EXEC;
          OP_ADDI:      state_nxt = S_IEXEC;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_BNE:       state_nxt = BNE_EN ? S_BRANCH : bad_nxt;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = bad_nxt;
        endcase
      end
      S_MEMADR: state_nxt = (Op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (ack) state_nxt = S_MEMWB;
      S_MEMWR:  if (ack) state_nxt = S_FETCH;
      S_EXEC:   state_nxt = S_RWB;
      S_IEXEC:  state_nxt = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // illegal rises together with the entry into TRAP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_TRAP) illegal <= 1'b1;
    end
  end

  multicycle_control_dec u_dec (
    .state (state),
    .ack   (ack),
    .op    (Op_i),
    .ctrl  (ctrl)
  );

  assign pc_wr_o      = ctrl.pc_wr;
  assign pc_wr_cond_o = ctrl.pc_wr_cond;
  assign br_ne_o      = ctrl.br_ne;
  assign pc_src_o     = ctrl.pc_src;
  assign iord_o       = ctrl.iord;
  assign mem_rd_o     = ctrl.mem_rd;
  assign mem_wr_o     = ctrl.mem_wr;
  assign ir_wr_o      = ctrl.ir_wr;
  assign reg_wr_o     = ctrl.reg_wr;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign alu_op_o     = ctrl.alu_op;
  assign illegal_o    = illegal;
  assign state_o      = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (no-ack/bne/no-trap and
// ack/no-bne/trap) driven cycle by cycle against a queue of expected words.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst, start, ack;
  logic [1:0][5:0] op;
  logic [1:0]      pc_wr, pc_wr_cond, br_ne, iord, mem_rd, mem_wr, ir_wr;
  logic [1:0]      reg_wr, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0][1:0] pc_src, alu_src_b, alu_op;
  logic [1:0][3:0] state;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

  multicycle_control #(.USE_ACK(1'b0), .BNE_EN(1'b1), .TRAP_EN(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .Op_i(op[0]),
    .mem_ack_i(ack[0]), .pc_wr_o(pc_wr[0]), .pc_wr_cond_o(pc_wr_cond[0]),
    .br_ne_o(br_ne[0]), .pc_src_o(pc_src[0]), .iord_o(iord[0]),
    .mem_rd_o(mem_rd[0]), .mem_wr_o(mem_wr[0]), .ir_wr_o(ir_wr[0]),
    .reg_wr_o(reg_wr[0]), .reg_dst_o(reg_dst[0]), .mem_to_reg_o(mem_to_reg[0]),
    .alu_src_a_o(alu_src_a[0]), .alu_src_b_o(alu_src_b[0]), .alu_op_o(alu_op[0]),
    .illegal_o(illegal[0]), .state_o(state[0])
  );

  multicycle_control #(.USE_ACK(1'b1), .BNE_EN(1'b0), .TRAP_EN(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .Op_i(op[1]),
    .mem_ack_i(ack[1]), .pc_wr_o(pc_wr[1]), .pc_wr_cond_o(pc_wr_cond[1]),
    .br_ne_o(br_ne[1]), .pc_src_o(pc_src[1]), .iord_o(iord[1]),
    .mem_rd_o(mem_rd[1]), .mem_wr_o(mem_wr[1]), .ir_wr_o(ir_wr[1]),
    .reg_wr_o(reg_wr[1]), .reg_dst_o(reg_dst[1]), .mem_to_reg_o(mem_to_reg[1]),
    .alu_src_a_o(alu_src_a[1]), .alu_src_b_o(alu_src_b[1]), .alu_op_o(alu_op[1]),
    .illegal_o(illegal[1]), .state_o(state[1])
  );

  typedef struct {
    int          inst;
    logic [21:0] vec;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic logic [21:0] obs(input int i);
    return {state[i], illegal[i], pc_wr[i], pc_wr_cond[i], br_ne[i], pc_src[i],
            iord[i], mem_rd[i], mem_wr[i], ir_wr[i], reg_wr[i], reg_dst[i],
            mem_to_reg[i], alu_src_a[i], alu_src_b[i], alu_op[i]};
  endfunction

  // Expected control word for a state, written out from the state table.
  function automatic logic [21:0] exp_out(input logic [3:0] st, input logic a,
                                          input logic [5:0] o, input logic il);
    logic pw, pwc, bn, ior, mr, mw, irw, rw, rd, m2r, sa;
    logic [1:0] ps, sb, ao;
    {pw, pwc, bn, ior, mr, mw, irw, rw, rd, m2r, sa} = '0;
    {ps, sb, ao} = '0;
    case (st)
      4'd1:  begin mr = 1; sb = 2'b01; ao = 2'b01; irw = a; pw = a; end
      4'd2:  begin sb = 2'b11; ao = 2'b01; end
      4'd3:  begin sa = 1; sb = 2'b10; ao = 2'b01; end
      4'd4:  begin mr = 1; ior = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mw = 1; ior = 1; end
      4'd7:  begin sa = 1; sb = 2'b00; ao = 2'b00; end
      4'd8:  begin rw = 1; rd = 1; end
      4'd9:  begin sa = 1; ao = 2'b10; pwc = 1; ps = 2'b01; bn = (o == 6'b000101); end
      4'd10: begin pw = 1; ps = 2'b10; end
      4'd11: begin sa = 1; sb = 2'b10; ao = 2'b01; end
      4'd12: rw = 1;
      default: ;
    endcase
    return {st, il, pw, pwc, bn, ps, ior, mr, mw, irw, rw, rd, m2r, sa, sb, ao};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic cyc(input int i, input logic r, input logic s, input logic a,
                     input logic [5:0] o, input logic [3:0] st, input logic il,
                     input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst[i] = r; start[i] = s; ack[i] = a; op[i] = o;
    e.inst = i;
    e.tag  = tag;
    e.vec  = r ? 22'd0 : exp_out(st, (i == 0) ? 1'b1 : a, o, il);
    sbq.push_back(e);
  endtask

  task automatic c0(input logic [5:0] o, input logic [3:0] st, input string tag);
    cyc(0, 1'b0, 1'b0, 1'b0, o, st, 1'b0, tag);
  endtask

  task automatic c1(input logic a, input logic [5:0] o, input logic [3:0] st,
                    input logic il, input string tag);
    cyc(1, 1'b0, 1'b0, a, o, st, il, tag);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, {10'd0, obs(e.inst)}, {10'd0, e.vec});
      check("rd_wr_excl", {31'd0, mem_rd[e.inst] & mem_wr[e.inst]}, 32'd0);
      check("reg_pc_excl", {31'd0, reg_wr[e.inst] & pc_wr[e.inst]}, 32'd0);
    end
  end

  initial begin
    rst = 2'b11; start = 2'b00; ack = 2'b00; op = '0;

    // instance 0: USE_ACK=0, BNE_EN=1, TRAP_EN=0
    cyc(0, 1'b1, 1'b0, 1'b0, LW, 4'd0, 1'b0, "rst0");
    cyc(0, 1'b0, 1'b1, 1'b0, LW, 4'd0, 1'b0, "idle0");
    c0(LW, 4'd1, "lw_fetch"); c0(LW, 4'd2, "lw_dec"); c0(LW, 4'd3, "lw_adr");
    c0(LW, 4'd4, "lw_rd");    c0(LW, 4'd5, "lw_wb");
    c0(BAD, 4'd1, "nop_fetch"); c0(BAD, 4'd2, "nop_dec");
    c0(RT, 4'd1, "r_fetch");   c0(RT, 4'd2, "r_dec");    c0(RT, 4'd7, "r_exec");
    c0(RT, 4'd8, "r_wb");
    c0(ADDI, 4'd1, "i_fetch"); c0(ADDI, 4'd2, "i_dec");  c0(ADDI, 4'd11, "i_exec");
    c0(ADDI, 4'd12, "i_wb");
    c0(JMP, 4'd1, "j_fetch");  c0(JMP, 4'd2, "j_dec");   c0(JMP, 4'd10, "j_jump");
    c0(BNE, 4'd1, "bne_fetch"); c0(BNE, 4'd2, "bne_dec"); c0(BNE, 4'd9, "bne_br");
    c0(BEQ, 4'd1, "beq_fetch"); c0(BEQ, 4'd2, "beq_dec"); c0(BEQ, 4'd9, "beq_br");
    c0(RT, 4'd1, "fetch_again");

    // instance 1: USE_ACK=1, BNE_EN=0, TRAP_EN=1
    cyc(1, 1'b1, 1'b0, 1'b0, SW, 4'd0, 1'b0, "rst1");
    cyc(1, 1'b0, 1'b1, 1'b0, SW, 4'd0, 1'b0, "idle1");
    c1(1'b0, SW, 4'd1, 1'b0, "f_wait"); c1(1'b0, SW, 4'd1, 1'b0, "f_wait");
    c1(1'b1, SW, 4'd1, 1'b0, "f_ack");
    c1(1'b1, SW, 4'd2, 1'b0, "sw_dec"); c1(1'b1, SW, 4'd3, 1'b0, "sw_adr");
    for (int k = 0; k < 3; k++) c1(1'b0, SW, 4'd6, 1'b0, "sw_wait");
    c1(1'b1, SW, 4'd6, 1'b0, "sw_ack");
    c1(1'b1, LW, 4'd1, 1'b0, "sw_ret");
    c1(1'b0, LW, 4'd2, 1'b0, "lw_dec1"); c1(1'b0, LW, 4'd3, 1'b0, "lw_adr1");
    c1(1'b0, LW, 4'd4, 1'b0, "lw_rd_wait");
    cyc(1, 1'b1, 1'b0, 1'b0, LW, 4'd0, 1'b0, "rst_mid");
    cyc(1, 1'b0, 1'b1, 1'b0, BNE, 4'd0, 1'b0, "idle_restart");
    c1(1'b1, BNE, 4'd1, 1'b0, "restart_fetch");
    c1(1'b0, BNE, 4'd2, 1'b0, "bne_ill_dec");
    for (int k = 0; k < 20; k++) begin
      cyc(1, 1'b0, 1'b1, k[0], BNE, 4'd13, 1'b1, "trap_hold");
    end
    cyc(1, 1'b1, 1'b0, 1'b0, RT, 4'd0, 1'b0, "trap_rst");
    c1(1'b1, RT, 4'd0, 1'b0, "idle_stay");

    @(posedge clk);
    @(negedge clk);
    #1;
    check("sb_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
